alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//   Multi-cycle controller that runs WIDTH-bit operations through one shared alu_4bit instance.
//   Each cycle processes one nibble, LSB first, and chains carry-out into the next nibble's carry-in.
//   Sits between a requester (valid/ready command) and a consumer (valid/ready result).
//   Serialising this way lets wide adds reuse the 4-bit ALU instead of replicating it.
// PARAMETERS
//   WIDTH  16  operand/result width; multiple of 4, >= 4; NIB = WIDTH/4 nibble steps
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start_valid  in   1      command present
//   start_ready  out  1      sequencer can accept command (IDLE only)
//   op_a         in   WIDTH  operand A, sampled on accept
//   op_b         in   WIDTH  operand B, sampled on accept
//   opcode       in   2      alu_4bit opcode, sampled on accept, held for whole op (2'b00 = add)
//   cin          in   1      carry-in to nibble 0, sampled on accept
//   res_valid    out  1      result/cout/zero valid
//   res_ready    in   1      consumer takes result
//   result       out  WIDTH  assembled result
//   cout         out  1      carry-out of final nibble
//   zero         out  1      result == 0
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset
//     Next edge -> IDLE; nib_cnt = 0.
//     result, cout, zero, res_valid and busy all = 0; start_ready = 1.
//     Reset mid-op aborts with no result delivered.
//   FSM: IDLE -> RUN -> DONE -> IDLE
//     IDLE: start_ready = 1.
//       On start_valid at an edge: latch op_a, op_b, opcode; carry_q <= cin; nib_cnt <= 0; go to RUN.
//     RUN: start_ready = 0. Each edge:
//       - Drive alu_4bit with a_sh[3:0], b_sh[3:0], opcode_q and carry_q.
//       - Shift a_sh and b_sh right by 4.
//       - res_sh <= {alu_res, res_sh[WIDTH-1:4]}.
//       - carry_q <= alu_cout; nib_cnt++.
//       - The edge with nib_cnt == NIB-1 goes to DONE.
//     DONE: res_valid = 1; result = res_sh; cout = carry_q; zero = (res_sh == 0).
//       Outputs stay stable while res_ready = 0.
//       On res_ready at an edge: go to IDLE and drop res_valid.
//   Latency
//     Command accepted at edge E0; res_valid first high after edge E0+NIB (4 cycles at WIDTH = 16).
//     Minimum issue interval is NIB+2 cycles.
//   Handshakes
//     start_valid is ignored outside IDLE, including in DONE when res_ready is high in the same cycle.
//       That command is accepted no earlier than the following cycle.
//     op_a, op_b, opcode and cin may change freely after accept.
//   Widths and arithmetic
//     Carry is chained for every opcode; the final nibble's carry is reported as cout.
//     No sign or overflow handling. Result is modulo 2^WIDTH.
//     Carry wraps through all nibbles: 0xFFFF + 1 -> 0x0000 with cout = 1.
//   Output holding
//     In IDLE, result, cout and zero hold their last delivered values (0 after reset).
// TESTING
//   1. Reset: assert rst 2 cycles -> res_valid = 0, busy = 0, result = 0, cout = 0, start_ready = 1.
//   2. ADD 0x1234 + 0x0FFF, cin = 0 -> result = 0x2233, cout = 0, zero = 0.
//      res_valid rises exactly 4 cycles after accept.
//   3. ADD 0xFFFF + 0x0001, cin = 0 -> result = 0x0000, cout = 1, zero = 1 (full carry ripple).
//   4. ADD 0x0000 + 0x0000, cin = 1 -> result = 0x0001, cout = 0.
//   5. Hold res_ready = 0 for 5 cycles in DONE with start_valid = 1:
//      result, cout and zero stay stable; start_ready = 0; no accept.
//      Then res_ready = 1 -> IDLE next cycle; new command is accepted the cycle after.
//   6. Assert rst after 2 nibbles in RUN -> IDLE next edge, all outputs 0.
//      A following 0x00FF + 0x0001 -> 0x0100, cout = 0.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial ALU sequencer: runs WIDTH-bit operations through a single
// 4-bit ALU, one nibble per cycle, LSB first, with the carry chained between
// nibbles. Command and result both use valid/ready handshakes.
//
// alu_4bit opcodes (the carry is chained for every opcode):
//   2'b00 ADD : {cout,res} = a + b + cin
//   2'b01 SUB : {cout,res} = a + ~b + cin   (cin = 1 gives a - b)
//   2'b10 AND : res = a & b, cout = cin     (carry passes through)
//   2'b11 XOR : res = a ^ b, cout = cin     (carry passes through)

module alu_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] op_i,
  input  logic       cin_i,
  output logic [3:0] res_o,
  output logic       cout_o
);

  logic [4:0] sum;

  // Combinational 4-bit ALU slice.
  always_comb begin
    sum    = '0;
    res_o  = '0;
    cout_o = 1'b0;
    unique case (op_i)
      2'b00: begin
        sum    = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
        res_o  = sum[3:0];
        cout_o = sum[4];
      end
      2'b01: begin
        sum    = {1'b0, a_i} + {1'b0, ~b_i} + {4'b0000, cin_i};
        res_o  = sum[3:0];
        cout_o = sum[4];
      end
      2'b10: begin
        res_o  = a_i & b_i;
        cout_o = cin_i;
      end
      default: begin
        res_o  = a_i ^ b_i;
        cout_o = cin_i;
      end
    endcase
  end

endmodule

module alu_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       opcode,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, res_sh_d;
  logic [1:0]       opcode_q;
  logic             carry_q;
  logic [CW-1:0]    nib_cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic [3:0]       alu_res;
  logic             alu_cout;
  logic             last_nib;

  alu_4bit u_alu (
    .a_i    (a_sh_q[3:0]),
    .b_i    (b_sh_q[3:0]),
    .op_i   (opcode_q),
    .cin_i  (carry_q),
    .res_o  (alu_res),
    .cout_o (alu_cout)
  );

  // Shift-and-insert written with shifts so it stays legal when WIDTH == 4.
  assign res_sh_d = (res_sh_q >> 4) | (WIDTH'(alu_res) << (WIDTH - 4));
  assign last_nib = (nib_cnt_q == CW'(NIB - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_valid) state_d = S_RUN;
      S_RUN:   if (last_nib)    state_d = S_DONE;
      S_DONE:  if (res_ready)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, nibble stepping and delivered-result registers.
  // The delivered result is captured on the final RUN edge so it holds
  // through IDLE and the next RUN until a new result replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      opcode_q  <= '0;
      carry_q   <= 1'b0;
      nib_cnt_q <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_sh_q    <= op_a;
            b_sh_q    <= op_b;
            opcode_q  <= opcode;
            carry_q   <= cin;
            nib_cnt_q <= '0;
            res_sh_q  <= '0;
          end
        end
        S_RUN: begin
          a_sh_q    <= a_sh_q >> 4;
          b_sh_q    <= b_sh_q >> 4;
          res_sh_q  <= res_sh_d;
          carry_q   <= alu_cout;
          nib_cnt_q <= nib_cnt_q + CW'(1);
          if (last_nib) begin
            result_q <= res_sh_d;
            cout_q   <= alu_cout;
            zero_q   <= (res_sh_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer (WIDTH = 16).
module tb_alu_nibble_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [1:0]       opcode = 2'b00;
  logic             cin = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_res;
  logic             exp_cout;
  logic             exp_zero;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .opcode      (opcode),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Whole-word reference: {cout, result}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0] op,
                                           input logic ci);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
      2'b01:   return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(ci);
      2'b10:   return {ci, a & b};
      default: return {ci, a ^ b};
    endcase
  endfunction

  // Present a command at a negedge while IDLE; returns at the negedge after accept.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic ci);
    logic [WIDTH:0] m;
    m = model(a, b, op, ci);
    exp_res  = m[WIDTH-1:0];
    exp_cout = m[WIDTH];
    exp_zero = (m[WIDTH-1:0] == '0);
    op_a = a; op_b = b; opcode = op; cin = ci; start_valid = 1'b1;
    n_checks++;
    if (start_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got=%b want=1", start_ready); end
    @(negedge clk);
    start_valid = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); opcode = 2'($urandom); cin = 1'($urandom);
  endtask

  // Called at the negedge just after accept: checks latency, result, hold and release.
  task automatic finish_op(input int delay);
    for (int k = 0; k < int'(NIB); k++) begin
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL latency_early k=%0d res_valid=%b busy=%b want 0/1", k, res_valid, busy);
      end
      @(negedge clk);
    end
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got=%b want=1", res_valid); end
    n_checks++;
    if (result !== exp_res || cout !== exp_cout || zero !== exp_zero) begin
      n_fail++; $display("FAIL result got=%h/%b/%b want=%h/%b/%b", result, cout, zero, exp_res, exp_cout, exp_zero);
    end
    res_ready = 1'b0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || result !== exp_res || cout !== exp_cout) begin
        n_fail++; $display("FAIL hold d=%0d valid=%b res=%h want 1/%h", d, res_valid, result, exp_res);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || result !== exp_res || zero !== exp_zero) begin
      n_fail++; $display("FAIL release valid=%b busy=%b ready=%b res=%h want 0/0/1/%h", res_valid, busy, start_ready, result, exp_res);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset valid=%b busy=%b res=%h cout=%b zero=%b ready=%b", res_valid, busy, result, cout, zero, start_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    issue(16'h1234, 16'h0FFF, 2'b00, 1'b0); finish_op(0);
    issue(16'hFFFF, 16'h0001, 2'b00, 1'b0); finish_op(1);
    issue(16'h0000, 16'h0000, 2'b00, 1'b1); finish_op(0);
    issue(16'h1000, 16'h0001, 2'b01, 1'b1); finish_op(0);
    issue(16'hF0F0, 16'h3C3C, 2'b10, 1'b1); finish_op(0);
    issue(16'hF0F0, 16'h3C3C, 2'b11, 1'b0); finish_op(0);
  endtask

  task automatic test_hold_in_done;
    logic [WIDTH-1:0] h_res;
    logic h_cout, h_zero;
    issue(16'h8001, 16'h8001, 2'b00, 1'b0);
    for (int k = 0; k < int'(NIB); k++) @(negedge clk);
    h_res = exp_res; h_cout = exp_cout; h_zero = exp_zero;
    n_checks++;
    if (res_valid !== 1'b1 || result !== 16'h0002 || cout !== 1'b1) begin
      n_fail++; $display("FAIL hold_entry valid=%b res=%h cout=%b want 1/0002/1", res_valid, result, cout);
    end
    op_a = 16'h00FF; op_b = 16'h0F01; opcode = 2'b00; cin = 1'b0;
    start_valid = 1'b1; res_ready = 1'b0;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || result !== h_res || cout !== h_cout || zero !== h_zero) begin
        n_fail++; $display("FAIL hold_stable d=%0d valid=%b ready=%b res=%h", d, res_valid, start_ready, result);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release valid=%b busy=%b ready=%b want 0/0/1", res_valid, busy, start_ready);
    end
    exp_res = 16'h1000; exp_cout = 1'b0; exp_zero = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_next_accept busy=%b ready=%b want 1/0", busy, start_ready);
    end
    finish_op(0);
  endtask

  task automatic test_reset_mid_run;
    issue(16'h1234, 16'h0FFF, 2'b00, 1'b0); finish_op(0);
    issue(16'hFFFF, 16'hFFFF, 2'b00, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || cout !== 1'b0 || zero !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset valid=%b busy=%b res=%h cout=%b zero=%b ready=%b", res_valid, busy, result, cout, zero, start_ready);
    end
    issue(16'h00FF, 16'h0001, 2'b00, 1'b0); finish_op(0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'($urandom));
      finish_op(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 16'hFFFF : WIDTH'($urandom);
      issue(a, WIDTH'(i), 2'b00, 1'($urandom));
      finish_op(0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_hold_in_done;
    test_reset_mid_run;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
